// File: rtl/mul_table_seq_pkg.sv
// Shared definitions for the multiplication-table sequencer.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Contents: FSM state encoding (IDLE/RUN/DONE), default table dimensions,
//           index/product width constants and a small dimension helper.
package mul_table_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default table geometry and bus widths.
  localparam int DEF_ROWS = 5;
  localparam int DEF_COLS = 5;
  localparam int DEF_IW   = 3;
  localparam int DEF_PW   = 2 * DEF_IW;

  // Smaller of two table dimensions.
  // The symmetric sweep stops at this row.
  function automatic int min_dim(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/mul_table_seq_if.sv
// Entry output bus of the multiplication-table sequencer.
// Latency: n/a (wires only). Backpressure: valid/ready, entry held while out_ready low.
// Ports: master drives out_valid/out_i/out_j/out_p/out_last and samples out_ready;
//        slave is the mirror image.
interface mul_table_seq_if
  import mul_table_pkg::*;
#(
  parameter int IW = DEF_IW,
  parameter int PW = DEF_PW
);
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_i;
  logic [IW-1:0] out_j;
  logic [PW-1:0] out_p;
  logic          out_last;

  modport master (
    output out_valid,
    output out_i,
    output out_j,
    output out_p,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_i,
    input  out_j,
    input  out_p,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/mul_table_seq_counter.sv
// Wrapping index counter used for both table row and table column.
// Latency: 1 cycle (registered count). Backpressure: counts only when en is high.
// Ports:
//   clock, reset - clock and async active-high reset
//   clr          - synchronous clear to zero (wins over en)
//   en           - advance
//   ld_val       - value taken when advancing from LIMIT
//   cnt_q        - current count
//   cnt_d        - next count, exposed so the parent can register derived values in step
//   wrap         - cnt_q == LIMIT
module mul_table_counter
  import mul_table_pkg::*;
#(
  parameter int           W     = DEF_IW,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] cnt_q,
  output logic [W-1:0] cnt_d,
  output logic         wrap
);

  assign wrap = (cnt_q == LIMIT);

  // The increment is only taken below LIMIT, so cnt_q + 1 never overflows W bits.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? ld_val : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mul_table_seq.sv
// Multiplication-table sequencer: on start, emits (i, j, i*j) for every table entry in row-major order.
// Latency: first entry valid 1 cycle after start; then 1 entry/cycle while out_ready is high.
// Backpressure: valid/ready; the entry is held stable while out_ready is low. done pulses after the last transfer.
// Ports:
//   clock, reset - clock and async active-high reset
//   start        - begins a sweep; sampled only in IDLE
//   out_bus      - entry bus (out_valid/out_ready/out_i/out_j/out_p/out_last)
//   busy         - sweep in progress
//   done         - one-cycle pulse after the final entry is accepted
// Option: MUL_TABLE_SEQ_SYMMETRIC_EN emits only the upper triangle (j >= i).
//         Undefined, the full ROWS x COLS rectangle is emitted.
module mul_table_seq
  import mul_table_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int IW   = DEF_IW,
  parameter int PW   = 2 * IW
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  mul_table_seq_if.master       out_bus,
  output logic                  busy,
  output logic                  done
);

  localparam logic [IW-1:0] COL_MAX = IW'(COLS - 1);

  // The row counter's limit is the last row of the sweep.
  // out_last is then simply "both counters at their limit".
`ifdef MUL_TABLE_SEQ_SYMMETRIC_EN
  localparam logic [IW-1:0] ROW_MAX = IW'(min_dim(ROWS, COLS) - 1);
`else
  localparam logic [IW-1:0] ROW_MAX = IW'(ROWS - 1);
`endif

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic          i_wrap, j_wrap;
  logic [IW-1:0] j_ld;
  logic [PW-1:0] p_q, p_d;
  logic          out_last;
  logic          xfer;
  logic          sweep_start;
  logic          sweep_end;
  logic          cnt_clr;
  logic          i_en, j_en;

  assign xfer        = out_bus.out_valid && out_bus.out_ready;
  assign out_last    = (state_q == RUN) && i_wrap && j_wrap;
  assign sweep_start = (state_q == IDLE) && start;
  assign sweep_end   = xfer && out_last;

  // Indices return to zero both when a sweep begins and when it finishes.
  // This keeps IDLE/DONE outputs at zero.
  assign cnt_clr = sweep_start || sweep_end;
  assign j_en    = xfer && !out_last;
  assign i_en    = j_en && j_wrap;

  // On a row change, the symmetric sweep restarts the column at the new row index.
`ifdef MUL_TABLE_SEQ_SYMMETRIC_EN
  assign j_ld = i_d;
`else
  assign j_ld = '0;
`endif

  mul_table_counter #(
    .W     (IW),
    .LIMIT (ROW_MAX)
  ) u_row_cnt (
    .clock  (clock),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (i_en),
    .ld_val ('0),
    .cnt_q  (i_q),
    .cnt_d  (i_d),
    .wrap   (i_wrap)
  );

  mul_table_counter #(
    .W     (IW),
    .LIMIT (COL_MAX)
  ) u_col_cnt (
    .clock  (clock),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (j_en),
    .ld_val (j_ld),
    .cnt_q  (j_q),
    .cnt_d  (j_d),
    .wrap   (j_wrap)
  );

  // The product is registered from the next indices.
  // It therefore changes in the same cycle as out_i/out_j and never depends on out_ready combinationally.
  always_comb begin
    p_d = PW'(i_d) * PW'(j_d);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)     state_d = RUN;
      RUN:     if (sweep_end) state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
    end
  end

  assign out_bus.out_valid = (state_q == RUN);
  assign out_bus.out_i     = i_q;
  assign out_bus.out_j     = j_q;
  assign out_bus.out_p     = p_q;
  assign out_bus.out_last  = out_last;
  assign busy              = (state_q == RUN);
  assign done              = (state_q == DONE);

endmodule

// File: tb/tb_mul_table_seq.sv
`timescale 1ns/1ps
module tb_mul_table_seq;

  localparam int R  = 5;
  localparam int C  = 5;
  localparam int IW = 3;
  localparam int PW = 6;

  typedef struct packed {
    logic [IW-1:0] i;
    logic [IW-1:0] j;
    logic [PW-1:0] p;
    logic          last;
  } ent_t;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic start1;
  logic busy, done, busy1, done1;

  int   checks   = 0;
  int   failures = 0;
  ent_t exp_q[$];
  int   xfer_cnt = 0;
  bit   rand_ready = 1'b0;

  always #5 clock = ~clock;

  mul_table_seq_if #(.IW(IW), .PW(PW)) if0();
  mul_table_seq_if #(.IW(1),  .PW(2))  if1();

  mul_table_seq #(.ROWS(R), .COLS(C), .IW(IW), .PW(PW)) u_dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .out_bus (if0),
    .busy    (busy),
    .done    (done)
  );

  mul_table_seq #(.ROWS(1), .COLS(1), .IW(1), .PW(2)) u_dut1 (
    .clock   (clock),
    .reset   (reset),
    .start   (start1),
    .out_bus (if1),
    .busy    (busy1),
    .done    (done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference sweep: the list of table entries in emission order.
  // The final one is flagged last. Returns the entry count.
  function automatic int push_sweep();
    int n = 0;
    int last_row;
    int j0;
`ifdef MUL_TABLE_SEQ_SYMMETRIC_EN
    last_row = ((R < C) ? R : C) - 1;
`else
    last_row = R - 1;
`endif
    for (int i = 0; i <= last_row; i++) begin
`ifdef MUL_TABLE_SEQ_SYMMETRIC_EN
      j0 = i;
`else
      j0 = 0;
`endif
      for (int j = j0; j < C; j++) begin
        ent_t e;
        e.i    = IW'(i);
        e.j    = IW'(j);
        e.p    = PW'(i * j);
        e.last = 1'b0;
        exp_q.push_back(e);
        n++;
      end
    end
    exp_q[exp_q.size() - 1].last = 1'b1;
    return n;
  endfunction

  // Ready driver: either always ready or a coin flip each cycle.
  initial begin
    forever begin
      @(posedge clock);
      #1 if0.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor and scoreboard.
  ent_t held;
  bit   hold_vld = 1'b0;
  bit   prev_last_xfer = 1'b0;
  always @(negedge clock) begin : monitor
    ent_t cur;
    cur.i    = if0.out_i;
    cur.j    = if0.out_j;
    cur.p    = if0.out_p;
    cur.last = if0.out_last;
    if (reset) begin
      hold_vld       = 1'b0;
      prev_last_xfer = 1'b0;
      exp_q.delete();
    end else begin
      check("done_timing", 32'(done), 32'(prev_last_xfer));
      check("busy_vs_valid", 32'(busy), 32'(if0.out_valid));
      if (hold_vld) begin
        check("stall_valid", 32'(if0.out_valid), 32'd1);
        check("stall_hold", 32'(cur), 32'(held));
      end
      hold_vld       = 1'b0;
      prev_last_xfer = 1'b0;
      if (if0.out_valid && if0.out_ready) begin
        xfer_cnt++;
        prev_last_xfer = cur.last;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_entry: got 0x%0h, expected no entry", cur);
        end else begin
          check("entry", 32'(cur), 32'(exp_q.pop_front()));
        end
      end else if (if0.out_valid) begin
        hold_vld = 1'b1;
        held     = cur;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    bit got = 1'b0;
    n = 0;
    while (!got && n < budget) begin
      @(negedge clock);
      n++;
      if (done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no done within %0d cycles, expected one", budget);
    end
  endtask

  task automatic wait_xfers(input int base, input int k);
    int c = 0;
    while ((xfer_cnt - base) < k && c < 2000) begin
      @(posedge clock);
      c++;
    end
    if ((xfer_cnt - base) < k) begin
      checks++;
      failures++;
      $display("FAIL xfer_timeout: got %0d transfers, expected %0d", xfer_cnt - base, k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int n, n_exp, base;
    reset = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_valid", 32'(if0.out_valid), 32'd0);
    check("rst_i",     32'(if0.out_i),     32'd0);
    check("rst_j",     32'(if0.out_j),     32'd0);
    check("rst_p",     32'(if0.out_p),     32'd0);
    check("rst_last",  32'(if0.out_last),  32'd0);
    check("rst_busy",  32'(busy),          32'd0);
    check("rst_done",  32'(done),          32'd0);
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_valid", 32'(if0.out_valid), 32'd0);

    // Full sweep with out_ready held high: back-to-back entries.
    // Then a start coinciding with done.
    n_exp = push_sweep();
    base  = xfer_cnt;
    pulse_start();
    @(negedge clock);
    check("first_valid_latency", 32'(if0.out_valid), 32'd1);
    wait_done(1000, n);
    check("b2b_done_cycle", 32'(n + 1), 32'(n_exp + 1));
    check("b2b_count", 32'(xfer_cnt - base), 32'(n_exp));
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("start_at_done_ignored", 32'(if0.out_valid), 32'd0);
    repeat (2) @(negedge clock);
    check("start_at_done_idle", 32'(busy), 32'd0);

    // Randomly stalled sweep.
    rand_ready = 1'b1;
    n_exp = push_sweep();
    base  = xfer_cnt;
    pulse_start();
    wait_done(2000, n);
    check("stall_count", 32'(xfer_cnt - base), 32'(n_exp));
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // Start pulsed mid-sweep is ignored.
    n_exp = push_sweep();
    base  = xfer_cnt;
    pulse_start();
    wait_xfers(base, 7);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(2000, n);
    check("midstart_count", 32'(xfer_cnt - base), 32'(n_exp));
    check("midstart_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-sweep: outputs clear immediately, no done.
    // The next start gives a fresh sweep.
    rand_ready = 1'b0;
    void'(push_sweep());
    base = xfer_cnt;
    pulse_start();
    wait_xfers(base, 12);
    @(negedge clock);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(if0.out_valid), 32'd0);
    check("arst_i",     32'(if0.out_i),     32'd0);
    check("arst_j",     32'(if0.out_j),     32'd0);
    check("arst_p",     32'(if0.out_p),     32'd0);
    check("arst_last",  32'(if0.out_last),  32'd0);
    check("arst_busy",  32'(busy),          32'd0);
    check("arst_done",  32'(done),          32'd0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    repeat (4) @(negedge clock);
    n_exp = push_sweep();
    base  = xfer_cnt;
    pulse_start();
    @(negedge clock);
    check("post_reset_first_valid", 32'(if0.out_valid), 32'd1);
    wait_done(1000, n);
    check("post_reset_done_cycle", 32'(n + 1), 32'(n_exp + 1));
    check("post_reset_drained", 32'(exp_q.size()), 32'd0);

    // 1x1 table: a single (0,0,0) entry flagged last, then done.
    @(posedge clock);
    #1 start1 = 1'b1;
    @(posedge clock);
    #1 start1 = 1'b0;
    @(negedge clock);
    check("one_valid", 32'(if1.out_valid), 32'd1);
    check("one_i",     32'(if1.out_i),     32'd0);
    check("one_j",     32'(if1.out_j),     32'd0);
    check("one_p",     32'(if1.out_p),     32'd0);
    check("one_last",  32'(if1.out_last),  32'd1);
    check("one_busy",  32'(busy1),         32'd1);
    @(negedge clock);
    check("one_done",      32'(done1),         32'd1);
    check("one_valid_end", 32'(if1.out_valid), 32'd0);
    @(negedge clock);
    check("one_done_pulse", 32'(done1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_table_seq.md
MUL_TABLE_SEQ -- requirements
Module: mul_table_seq

Interface
REQ-001 Parameter ROWS, default 5, row-index range 0..ROWS-1, ROWS >= 1.
REQ-002 Parameter COLS, default 5, column-index range 0..COLS-1, COLS >= 1.
REQ-003 Parameter IW, default 3, index width, SHALL satisfy 2**IW >= max(ROWS,COLS).
REQ-004 Parameter PW, default 2*IW, product width.
REQ-005 clock  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  pulse; begins a table sweep when IDLE.
REQ-008 out_valid  output  1  entry present on out_i/out_j/out_p.
REQ-009 out_ready  input  1  downstream accepts entry.
REQ-010 out_i  output  IW  row index.
REQ-011 out_j  output  IW  column index.
REQ-012 out_p  output  PW  product out_i*out_j.
REQ-013 out_last  output  1  high with final entry of sweep.
REQ-014 busy  output  1  high in state RUN.
REQ-015 done  output  1  one-cycle pulse after final entry accepted.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE.
REQ-017 IDLE + start -> RUN, i=0, j=0; out_valid high the next cycle (latency 1).
REQ-018 In RUN, out_valid SHALL stay high and out_i/out_j/out_p/out_last stable until out_ready sampled high.
REQ-019 Transfer (out_valid && out_ready) SHALL advance j; at j=COLS-1, j wraps to 0 and i increments (row-major order).
REQ-020 out_p SHALL be the unsigned product registered with the indices, never combinationally dependent on out_ready.
REQ-021 out_last SHALL be high iff current entry is the final entry of the sweep.
REQ-022 Transfer with out_last -> DONE; DONE asserts done for exactly one cycle, then -> IDLE.
REQ-023 start while RUN or DONE SHALL be ignored.
REQ-024 start in the same cycle as done SHALL be ignored; new sweep requires start in IDLE.
REQ-025 ROWS=1,COLS=1: single entry (0,0,0) with out_last high.
REQ-026 Back-to-back: with out_ready held high, one entry per cycle, no bubbles.

Reset
REQ-027 reset SHALL force IDLE, i=0, j=0, out_valid=0, out_i=0, out_j=0, out_p=0, out_last=0, busy=0, done=0, asynchronously.
REQ-028 reset mid-sweep SHALL abandon the sweep with no done pulse.

Configuration
REQ-029 Macro MUL_TABLE_SEQ_SYMMETRIC_EN defined: only entries with j >= i emitted; after row wrap j restarts at new i; final entry (min(ROWS,COLS)-1 row's last column, COLS-1).
REQ-030 Macro undefined: full ROWS*COLS rectangular sweep per REQ-019.

Structure
REQ-031 Package mul_table_pkg SHALL hold state encodings (IDLE/RUN/DONE) and index/product width constants.
REQ-032 Sub-module mul_table_counter: wrapping index counter with enable, load value and wrap flag; instantiated twice (row, column).
REQ-033 Target 120-400 lines of RTL in total.

Verification
REQ-034 Default 5x5, out_ready=1, start pulse -> 25 entries over 25 consecutive cycles, first (0,0,0), last (4,4,16) with out_last, done one cycle later.
REQ-035 out_ready toggled pseudo-randomly -> entries unchanged while stalled, sequence identical to REQ-034, no drops or duplicates.
REQ-036 start pulsed at entry 7 of sweep -> ignored, sweep completes with 25 entries.
REQ-037 reset asserted at entry 12 -> all outputs 0 immediately, no done; subsequent start -> full sweep from (0,0,0).
REQ-038 MUL_TABLE_SEQ_SYMMETRIC_EN, 5x5 -> 15 entries, e.g. (1,1,1),(1,2,2)...(4,4,16) last.
REQ-039 ROWS=1, COLS=1 -> single entry (0,0,0) with out_last, done next cycle.
